// File: rtl/cam_capture_ctrl.sv
// Frame-level capture sequencer for the OV7670 pixel path: gates datapath writes
// per frame (single-shot / continuous / frozen) and checks each frame's geometry.
module cam_capture_ctrl #(
  parameter int LINE_PX   = 320,
  parameter int NUM_LINES = 240,
  parameter int CW        = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic        cap_req,
  input  logic        cont_mode,
  input  logic        freeze,
  input  logic [2:0]  option,
  output logic        cap_en,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_sticky,
  output logic [7:0]  frame_cnt,
  output logic [15:0] leds
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [CW-1:0] LINE_BYTES = CW'(2 * LINE_PX);
  localparam logic [CW-1:0] LINE_TOTAL = CW'(NUM_LINES);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  logic [2:0]    state;
  logic          pas_vsync;
  logic          pas_href;
  logic          pas_cap;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] line_cnt;
  logic [CW-1:0] last_line_px;
  logic          bad_line;

  logic vs_fall;
  logic vs_rise;
  logic hr_rise;
  logic hr_fall;
  logic req;
  logic rearm;
  logic frame_good;

  assign vs_fall    = pas_vsync & ~vsync;
  assign vs_rise    = ~pas_vsync & vsync;
  assign hr_rise    = ~pas_href & href;
  assign hr_fall    = pas_href & ~href;
  assign req        = ~pas_cap & cap_req;
  assign rearm      = cont_mode & ~freeze;
  assign frame_good = (line_cnt == LINE_TOTAL) & ~bad_line;

  assign busy = (state == S_ARM) || (state == S_CAPTURE);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // frame_done is raised on the vs_rise edge so that it is high exactly during EVAL.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state        <= S_IDLE;
      pas_vsync    <= 1'b0;
      pas_href     <= 1'b0;
      pas_cap      <= 1'b0;
      byte_cnt     <= '0;
      line_cnt     <= '0;
      last_line_px <= '0;
      bad_line     <= 1'b0;
      cap_en       <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_sticky   <= 1'b0;
      frame_cnt    <= 8'd0;
      leds         <= 16'd0;
    end else begin
      pas_vsync  <= vsync;
      pas_href   <= href;
      pas_cap    <= cap_req;
      frame_done <= 1'b0;

      case (state)
        S_IDLE, S_HOLD: begin
          cap_en <= 1'b0;
          if (req || rearm) state <= S_ARM;
        end

        S_ARM: begin
          line_cnt <= '0;
          byte_cnt <= '0;
          bad_line <= 1'b0;
          cap_en   <= vs_fall;
          if (vs_fall) state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (hr_rise) begin
            line_cnt <= sat_inc(line_cnt);
            byte_cnt <= CW'(1);
          end else if (href) begin
            byte_cnt <= sat_inc(byte_cnt);
          end
          // A line ending on the same edge as vs_rise is still checked before EVAL.
          if (hr_fall) begin
            last_line_px <= byte_cnt >> 1;
            if (byte_cnt != LINE_BYTES) bad_line <= 1'b1;
          end
          if (vs_rise) begin
            state      <= S_EVAL;
            cap_en     <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        S_EVAL: begin
          frame_ok  <= frame_good;
          frame_cnt <= frame_cnt + 8'd1;
          if (!frame_good) err_sticky <= 1'b1;
          state <= rearm ? S_ARM : S_HOLD;
        end

        default: begin
          state  <= S_IDLE;
          cap_en <= 1'b0;
        end
      endcase

      case (option)
        3'd0:    leds <= {12'b0, err_sticky, frame_ok, busy, cap_en};
        3'd1:    leds <= 16'(line_cnt);
        3'd3:    leds <= 16'(last_line_px);
        3'd7:    leds <= {8'b0, frame_cnt};
        default: leds <= 16'd0;
      endcase
    end
  end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Frame-level sequencer for the OV7670 capture path. Runs on the camera pixel clock.
- Decides which frames the pixel-write datapath stores, through the cap_en gate: single-shot, continuous or frozen.
- Checks each captured frame's geometry (lines per frame, pixels per line) and reports frame status and statistics on the board LEDs.

Parameters:
- LINE_PX, 320, expected pixels per line (2 bytes per pixel, RGB565).
- NUM_LINES, 240, expected href lines per frame.
- CW, 16, width of the line and pixel counters.

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- rst  in  1  synchronous reset, active-low: logic is reset on a pclk rising edge while rst==0.
- vsync  in  1  camera vsync; high marks frame blanking.
- href  in  1  camera href; high marks valid line bytes.
- cap_req  in  1  single-shot capture button, level, already synchronized to pclk; acts on its rising edge.
- cont_mode  in  1  level; 1 selects continuous capture.
- freeze  in  1  level; 1 stops continuous re-arming.
- option  in  3  LED display select.
- cap_en  out  1  registered; enables datapath writes.
- busy  out  1  1 in ARM or CAPTURE.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_ok  out  1  result of the last evaluated frame.
- err_sticky  out  1  set by any bad frame; cleared only by reset.
- frame_cnt  out  8  count of captured frames; wraps 255->0.
- leds  out  16  status display.

Behaviour:
- Internal registers: pas_vsync, pas_href, pas_cap (one-cycle delayed copies), byte_cnt[CW], line_cnt[CW], last_line_px[CW], bad_line.
- Reset values: state=IDLE; cap_en=0; busy=0; frame_done=0; frame_ok=0; err_sticky=0; frame_cnt=0; leds=0; all counters=0; pas_vsync=0, pas_href=0, pas_cap=0.
- Edge definitions:
  - vs_fall = pas_vsync & ~vsync; vs_rise = ~pas_vsync & vsync.
  - hr_rise = ~pas_href & href; hr_fall = pas_href & ~href.
  - req = ~pas_cap & cap_req.
- The three delayed copies update every non-reset cycle, in every state.
- State IDLE:
  - cap_en=0.
  - req, or (cont_mode & ~freeze) -> ARM.
- State ARM:
  - cap_en=0; busy=1.
  - line_cnt, byte_cnt and bad_line held at 0.
  - On vs_fall -> CAPTURE, with cap_en=1 registered on the same edge. First write enable is therefore visible the cycle after vs_fall.
- State CAPTURE:
  - cap_en=1; busy=1.
  - hr_rise: line_cnt+1, saturating at 2^CW-1; byte_cnt=1, because the first byte is sampled this cycle.
  - href=1 and not hr_rise: byte_cnt+1, saturating.
  - hr_fall: last_line_px=byte_cnt>>1; if byte_cnt != 2*LINE_PX then bad_line=1.
  - vs_rise: -> EVAL; cap_en=0 on the same edge.
  - freeze does not abort a frame in progress; the current frame always completes.
- State EVAL (exactly 1 cycle):
  - frame_ok = (line_cnt==NUM_LINES) & ~bad_line.
  - frame_done=1 for this cycle only.
  - frame_cnt+1, modulo 256.
  - If the frame was bad, err_sticky=1.
  - Next: (cont_mode & ~freeze) -> ARM, else HOLD.
- State HOLD:
  - cap_en=0.
  - Captured memory contents stay valid for display.
  - req, or (cont_mode & ~freeze) -> ARM.
- Simultaneous events:
  - vs_rise and hr_fall in the same cycle: the line check completes before EVAL.
  - req while in ARM or CAPTURE: ignored, not queued.
- leds, registered every cycle:
  - option 1 -> line_cnt.
  - option 3 -> last_line_px.
  - option 7 -> {8'b0, frame_cnt}.
  - option 0 -> {12'b0, err_sticky, frame_ok, busy, cap_en}.
  - any other option -> 0.
- Reset asserted mid-frame: the next edge returns all registers to reset values and drops cap_en immediately. The partial frame is not counted.

Test Plan:
- Bench uses LINE_PX=4, NUM_LINES=3, with 2-cycle href gaps and a 10-cycle vsync pulse.
- 1) Single shot, cap_req pulse during vsync high, then one frame of 3 lines × 8 bytes:
  - cap_en rises the cycle after vs_fall and falls at vs_rise.
  - frame_done pulses once; frame_ok=1; frame_cnt=1; state ends in HOLD.
  - Idle gaps: a second frame with no new cap_req leaves cap_en=0.
- 2) Short line, middle line has 6 bytes:
  - frame_ok=0; err_sticky=1.
  - A following good frame gives frame_ok=1 with err_sticky still 1.
- 3) Line count error, frame with 4 lines: frame_ok=0; option=1 -> leds=16'h0004.
- 4) Continuous mode, cont_mode=1 for 3 frames, then freeze=1 asserted mid-frame 3:
  - Frame 3 completes; frame_cnt=3; state ends in HOLD.
  - cap_en stays 0 on frame 4.
- 5) Counter wrap: 256 continuous frames -> frame_cnt returns to 0; option=7 -> leds=16'h0000.
- 6) Reset mid-capture, rst=0 for 1 cycle during line 2:
  - Next cycle: cap_en=0, frame_cnt=0, leds=0, state=IDLE.
  - No frame_done pulse.
